// File: rtl/ps2_kbd_rx.sv
// PS/2 keyboard receiver: clock filter, 11-bit deframer with timeout, E0/F0 prefix tracking and
// a first-word-fall-through scancode FIFO. Define PS2_PARITY_CHECK_EN to enforce odd parity.
module ps2_kbd_rx #(
    parameter int unsigned FILTER_LEN  = 4,
    parameter int unsigned TIMEOUT_CYC = 100000,
    parameter int unsigned FIFO_DEPTH  = 4
) (
    input  logic                          clk_i,
    input  logic                          rst_ni,
    input  logic                          ps2_clk_i,
    input  logic                          ps2_data_i,
    output logic [7:0]                    code_o,
    output logic                          extended_o,
    output logic                          release_o,
    output logic                          valid_o,
    input  logic                          ready_i,
    output logic [$clog2(FIFO_DEPTH):0]   count_o,
    output logic                          overflow_o,
    output logic                          frame_err_o
);

    localparam int unsigned FLT_W = $clog2(FILTER_LEN + 1);
    localparam int unsigned TMO_W = $clog2(TIMEOUT_CYC + 1);
    localparam int unsigned PTR_W = $clog2(FIFO_DEPTH);
    localparam int unsigned CNT_W = PTR_W + 1;

    typedef enum logic [1:0] {
        StIdle,
        StData,
        StParity,
        StStop
    } state_e;

    // Input synchronisers and glitch filter
    logic             r_clk_meta, r_clk_sync;
    logic             r_dat_meta, r_dat_sync;
    logic             r_filt, r_filt_prev;
    logic [FLT_W-1:0] r_flt_cnt;
    logic             w_fall;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_clk_meta  <= 1'b1;
            r_clk_sync  <= 1'b1;
            r_dat_meta  <= 1'b1;
            r_dat_sync  <= 1'b1;
            r_filt      <= 1'b1;
            r_filt_prev <= 1'b1;
            r_flt_cnt   <= '0;
        end else begin
            r_clk_meta  <= ps2_clk_i;
            r_clk_sync  <= r_clk_meta;
            r_dat_meta  <= ps2_data_i;
            r_dat_sync  <= r_dat_meta;
            r_filt_prev <= r_filt;
            // Any sample agreeing with the filtered level restarts the run count.
            if (r_clk_sync == r_filt) begin
                r_flt_cnt <= '0;
            end else if (r_flt_cnt == FLT_W'(FILTER_LEN - 1)) begin
                r_filt    <= r_clk_sync;
                r_flt_cnt <= '0;
            end else begin
                r_flt_cnt <= r_flt_cnt + FLT_W'(1);
            end
        end
    end

    assign w_fall = r_filt_prev & ~r_filt;

    // Deframer state
    state_e           r_state, w_state_d;
    logic [2:0]       r_bit_cnt, w_bit_cnt_d;
    logic [7:0]       r_shift, w_shift_d;
    logic [TMO_W-1:0] r_tmo_cnt, w_tmo_cnt_d;
    logic             r_byte_vld, w_byte_vld_d;
    logic             r_ferr, w_ferr_d;
    logic             r_ext, w_ext_d;
    logic             r_brk, w_brk_d;
    logic             w_par_ok;
    logic             w_push;

`ifdef PS2_PARITY_CHECK_EN
    logic r_parity;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_parity <= 1'b0;
        end else if (r_state == StParity && w_fall) begin
            r_parity <= r_dat_sync;
        end
    end

    assign w_par_ok = ^{r_shift, r_parity};
`else
    assign w_par_ok = 1'b1;
`endif

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_state    <= StIdle;
            r_bit_cnt  <= '0;
            r_shift    <= '0;
            r_tmo_cnt  <= '0;
            r_byte_vld <= 1'b0;
            r_ferr     <= 1'b0;
            r_ext      <= 1'b0;
            r_brk      <= 1'b0;
        end else begin
            r_state    <= w_state_d;
            r_bit_cnt  <= w_bit_cnt_d;
            r_shift    <= w_shift_d;
            r_tmo_cnt  <= w_tmo_cnt_d;
            r_byte_vld <= w_byte_vld_d;
            r_ferr     <= w_ferr_d;
            r_ext      <= w_ext_d;
            r_brk      <= w_brk_d;
        end
    end

    always_comb begin
        w_state_d    = r_state;
        w_bit_cnt_d  = r_bit_cnt;
        w_shift_d    = r_shift;
        w_byte_vld_d = 1'b0;
        w_ferr_d     = 1'b0;
        w_ext_d      = r_ext;
        w_brk_d      = r_brk;
        w_push       = 1'b0;
        w_tmo_cnt_d  = (r_state == StIdle || w_fall) ? '0 : r_tmo_cnt + TMO_W'(1);

        case (r_state)
            StIdle: begin
                if (w_fall && !r_dat_sync) begin
                    w_state_d   = StData;
                    w_bit_cnt_d = '0;
                end
            end
            StData: begin
                if (w_fall) begin
                    w_shift_d   = {r_dat_sync, r_shift[7:1]};
                    w_bit_cnt_d = r_bit_cnt + 3'd1;
                    if (r_bit_cnt == 3'd7) begin
                        w_state_d = StParity;
                    end
                end
            end
            StParity: begin
                if (w_fall) begin
                    w_state_d = StStop;
                end
            end
            StStop: begin
                if (w_fall) begin
                    w_state_d = StIdle;
                    if (r_dat_sync && w_par_ok) begin
                        w_byte_vld_d = 1'b1;
                    end else begin
                        w_ferr_d = 1'b1;
                    end
                end
            end
            default: w_state_d = StIdle;
        endcase

        if (r_state != StIdle && !w_fall && r_tmo_cnt == TMO_W'(TIMEOUT_CYC - 1)) begin
            w_state_d = StIdle;
            w_ferr_d  = 1'b1;
        end

        // The completed byte stays in r_shift through the decode cycle.
        if (r_byte_vld) begin
            if (r_shift == 8'hE0) begin
                w_ext_d = 1'b1;
            end else if (r_shift == 8'hF0) begin
                w_brk_d = 1'b1;
            end else begin
                w_push  = 1'b1;
                w_ext_d = 1'b0;
                w_brk_d = 1'b0;
            end
        end

        if (w_ferr_d) begin
            w_ext_d = 1'b0;
            w_brk_d = 1'b0;
        end
    end

    // Scancode FIFO, entries are {extended, release, code}
    logic [9:0]       r_mem [FIFO_DEPTH];
    logic [PTR_W-1:0] r_wptr, r_rptr;
    logic [CNT_W-1:0] r_count;
    logic             r_ovf;
    logic             w_valid, w_pop, w_full, w_wr;

    assign w_valid = (r_count != '0);
    assign w_pop   = w_valid && ready_i;
    assign w_full  = (r_count == CNT_W'(FIFO_DEPTH));
    // A pop in the same cycle frees the slot, so a full FIFO can still accept.
    assign w_wr    = w_push && (!w_full || w_pop);

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                r_mem[i] <= '0;
            end
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_count <= '0;
            r_ovf   <= 1'b0;
        end else begin
            if (w_wr) begin
                r_mem[r_wptr] <= {r_ext, r_brk, r_shift};
                r_wptr        <= r_wptr + PTR_W'(1);
            end
            if (w_pop) begin
                r_rptr <= r_rptr + PTR_W'(1);
            end
            case ({w_wr, w_pop})
                2'b10:   r_count <= r_count + CNT_W'(1);
                2'b01:   r_count <= r_count - CNT_W'(1);
                default: r_count <= r_count;
            endcase
            r_ovf <= w_push && w_full && !w_pop;
        end
    end

    assign code_o      = r_mem[r_rptr][7:0];
    assign release_o   = r_mem[r_rptr][8];
    assign extended_o  = r_mem[r_rptr][9];
    assign valid_o     = w_valid;
    assign count_o     = r_count;
    assign overflow_o  = r_ovf;
    assign frame_err_o = r_ferr;

endmodule

// File: tb/tb_ps2_kbd_rx.sv
// Self-checking bench for ps2_kbd_rx: randomized PS/2 frames against a scancode-level model.
`timescale 1ns/1ps
module tb_ps2_kbd_rx;

    localparam int unsigned FILTER_LEN  = 4;
    localparam int unsigned TIMEOUT_CYC = 1000;
    localparam int unsigned FIFO_DEPTH  = 4;

    logic       clk_i = 1'b0;
    logic       rst_ni;
    logic       ps2_clk_i;
    logic       ps2_data_i;
    logic       ready_i;
    logic [7:0] code_o;
    logic       extended_o;
    logic       release_o;
    logic       valid_o;
    logic [$clog2(FIFO_DEPTH):0] count_o;
    logic       overflow_o;
    logic       frame_err_o;

    int errors = 0;
    int checks = 0;

    // Monitor-side records (written only by the monitor)
    logic [9:0] got_q[$];
    int         ferr_pulses  = 0;
    int         ovf_pulses   = 0;
    int         valid_cycles = 0;

    // Reference model state: scancode level, no framing detail
    logic       m_ext = 1'b0;
    logic       m_brk = 1'b0;
    logic [9:0] exp_q[$];

    always #5 clk_i = ~clk_i;

    ps2_kbd_rx #(
        .FILTER_LEN (FILTER_LEN),
        .TIMEOUT_CYC(TIMEOUT_CYC),
        .FIFO_DEPTH (FIFO_DEPTH)
    ) dut (
        .clk_i      (clk_i),
        .rst_ni     (rst_ni),
        .ps2_clk_i  (ps2_clk_i),
        .ps2_data_i (ps2_data_i),
        .code_o     (code_o),
        .extended_o (extended_o),
        .release_o  (release_o),
        .valid_o    (valid_o),
        .ready_i    (ready_i),
        .count_o    (count_o),
        .overflow_o (overflow_o),
        .frame_err_o(frame_err_o)
    );

    // Inputs only change #1 after posedge, so a negedge sample predicts the next edge's pop.
    always @(negedge clk_i) begin
        if (valid_o && ready_i) got_q.push_back({extended_o, release_o, code_o});
        if (valid_o) valid_cycles++;
        if (frame_err_o) ferr_pulses++;
        if (overflow_o) ovf_pulses++;
    end

    task automatic cycles(input int n);
        repeat (n) @(posedge clk_i);
        #1;
    endtask

    task automatic model_byte(input logic [7:0] b);
        if (b == 8'hE0) m_ext = 1'b1;
        else if (b == 8'hF0) m_brk = 1'b1;
        else begin
            exp_q.push_back({m_ext, m_brk, b});
            m_ext = 1'b0;
            m_brk = 1'b0;
        end
    endtask

    task automatic model_clear();
        m_ext = 1'b0;
        m_brk = 1'b0;
        exp_q.delete();
    endtask

    task automatic ps2_bit(input logic v, input bit glitch);
        ps2_data_i = v;
        if (glitch) begin
            cycles(4);
            ps2_clk_i = 1'b0;
            cycles(2);
            ps2_clk_i = 1'b1;
            cycles(4);
        end else begin
            cycles(10);
        end
        ps2_clk_i = 1'b0;
        cycles(20);
        ps2_clk_i = 1'b1;
        cycles(10);
    endtask

    task automatic send_frame(input logic [7:0] b, input bit bad_par, input int nedges,
                              input int glitch_bit);
        logic [10:0] f;
        f = {1'b1, (~^b) ^ bad_par, b, 1'b0};
        for (int i = 0; i < nedges; i++) ps2_bit(f[i], i == glitch_bit);
        ps2_data_i = 1'b1;
        cycles(10);
    endtask

    task automatic test_reset();
        logic [15:0] obs;
        rst_ni     = 1'b0;
        ps2_clk_i  = 1'b1;
        ps2_data_i = 1'b1;
        ready_i    = 1'b0;
        cycles(5);
        obs = {code_o, extended_o, release_o, valid_o, count_o, overflow_o, frame_err_o};
        checks++;
        if (obs !== 16'h0) begin
            errors++;
            $display("FAIL reset_in outputs=%h expected=0000", obs);
        end
        rst_ni = 1'b1;
        cycles(20);
        obs = {code_o, extended_o, release_o, valid_o, count_o, overflow_o, frame_err_o};
        checks++;
        if (obs !== 16'h0 || ferr_pulses != 0) begin
            errors++;
            $display("FAIL reset_after outputs=%h ferr=%0d expected=0000 ferr=0", obs, ferr_pulses);
        end
    endtask

    task automatic test_single();
        int base, vb, eb;
        model_clear();
        base = got_q.size();
        vb = valid_cycles;
        eb = ferr_pulses;
        ready_i = 1'b1;
        model_byte(8'h16);
        send_frame(8'h16, 1'b0, 11, -1);
        cycles(5);
        checks++;
        if (got_q.size() - base != 1 || got_q[base] !== exp_q[0]) begin
            errors++;
            $display("FAIL single_entry n=%0d got=%h expected n=1 %h", got_q.size() - base,
                     got_q.size() > base ? got_q[base] : 10'h0, exp_q[0]);
        end
        checks++;
        if (valid_cycles - vb != 1) begin
            errors++;
            $display("FAIL single_valid_len got=%0d expected=1", valid_cycles - vb);
        end
        checks++;
        if (ferr_pulses - eb != 0) begin
            errors++;
            $display("FAIL single_no_err got=%0d expected=0", ferr_pulses - eb);
        end
    endtask

    task automatic test_prefix();
        logic [7:0] seq [3];
        logic [2:0] cnt_exp [3];
        int base;
        seq = '{8'hE0, 8'hF0, 8'h75};
        cnt_exp = '{3'd0, 3'd0, 3'd1};
        model_clear();
        ready_i = 1'b0;
        for (int i = 0; i < 3; i++) begin
            model_byte(seq[i]);
            send_frame(seq[i], 1'b0, 11, -1);
            checks++;
            if (count_o !== cnt_exp[i]) begin
                errors++;
                $display("FAIL prefix_count_%0d got=%0d expected=%0d", i, count_o, cnt_exp[i]);
            end
        end
        checks++;
        if ({extended_o, release_o, code_o} !== exp_q[0]) begin
            errors++;
            $display("FAIL prefix_head got=%h expected=%h", {extended_o, release_o, code_o},
                     exp_q[0]);
        end
        ready_i = 1'b1;
        cycles(3);
        model_clear();
        base = got_q.size();
        model_byte(8'h1C);
        send_frame(8'h1C, 1'b0, 11, -1);
        checks++;
        if (got_q.size() - base != 1 || got_q[base] !== exp_q[0]) begin
            errors++;
            $display("FAIL prefix_cleared n=%0d got=%h expected=%h", got_q.size() - base,
                     got_q.size() > base ? got_q[base] : 10'h0, exp_q[0]);
        end
    endtask

    task automatic test_overflow();
        logic [7:0] codes [5];
        int base, ob;
        codes = '{8'h16, 8'h1E, 8'h26, 8'h25, 8'h2E};
        model_clear();
        ready_i = 1'b0;
        ob = ovf_pulses;
        for (int i = 0; i < 5; i++) begin
            model_byte(codes[i]);
            send_frame(codes[i], 1'b0, 11, -1);
        end
        checks++;
        if (count_o !== 3'(FIFO_DEPTH)) begin
            errors++;
            $display("FAIL ovf_count got=%0d expected=%0d", count_o, FIFO_DEPTH);
        end
        checks++;
        if (ovf_pulses - ob != 5 - FIFO_DEPTH) begin
            errors++;
            $display("FAIL ovf_pulses got=%0d expected=%0d", ovf_pulses - ob, 5 - FIFO_DEPTH);
        end
        base = got_q.size();
        ready_i = 1'b1;
        cycles(10);
        checks++;
        if (got_q.size() - base != FIFO_DEPTH) begin
            errors++;
            $display("FAIL ovf_drain_n got=%0d expected=%0d", got_q.size() - base, FIFO_DEPTH);
        end else begin
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                checks++;
                if (got_q[base + i] !== exp_q[i]) begin
                    errors++;
                    $display("FAIL ovf_order_%0d got=%h expected=%h", i, got_q[base + i], exp_q[i]);
                end
            end
        end
    endtask

    task automatic test_parity();
        int base, eb, exp_err, exp_n;
        base = got_q.size();
        eb = ferr_pulses;
        ready_i = 1'b1;
`ifdef PS2_PARITY_CHECK_EN
        exp_err = 1;
        exp_n   = 0;
`else
        exp_err = 0;
        exp_n   = 1;
`endif
        send_frame(8'h16, 1'b1, 11, -1);
        cycles(5);
        checks++;
        if (ferr_pulses - eb != exp_err || got_q.size() - base != exp_n) begin
            errors++;
            $display("FAIL parity err=%0d n=%0d expected err=%0d n=%0d", ferr_pulses - eb,
                     got_q.size() - base, exp_err, exp_n);
        end
        if (exp_n == 1 && got_q.size() > base) begin
            checks++;
            if (got_q[base] !== 10'h016) begin
                errors++;
                $display("FAIL parity_code got=%h expected=016", got_q[base]);
            end
        end
    endtask

    task automatic test_timeout();
        int base, eb;
        model_clear();
        ready_i = 1'b1;
        model_byte(8'hF0);
        send_frame(8'hF0, 1'b0, 11, -1);
        eb = ferr_pulses;
        send_frame(8'h45, 1'b0, 6, -1);
        cycles(TIMEOUT_CYC + 20);
        m_ext = 1'b0;
        m_brk = 1'b0;
        checks++;
        if (ferr_pulses - eb != 1) begin
            errors++;
            $display("FAIL timeout_err got=%0d expected=1", ferr_pulses - eb);
        end
        base = got_q.size();
        model_byte(8'h45);
        send_frame(8'h45, 1'b0, 11, 4);
        checks++;
        if (got_q.size() - base != 1 || got_q[base] !== exp_q[0]) begin
            errors++;
            $display("FAIL timeout_next n=%0d got=%h expected=%h", got_q.size() - base,
                     got_q.size() > base ? got_q[base] : 10'h0, exp_q[0]);
        end
        checks++;
        if (ferr_pulses - eb != 1) begin
            errors++;
            $display("FAIL glitch_err got=%0d expected=1", ferr_pulses - eb);
        end
    endtask

    task automatic test_reset_mid();
        logic [15:0] obs;
        int base, eb;
        model_clear();
        ready_i = 1'b1;
        send_frame(8'hF0, 1'b0, 11, -1);
        send_frame(8'h1E, 1'b0, 4, -1);
        rst_ni = 1'b0;
        cycles(3);
        obs = {code_o, extended_o, release_o, valid_o, count_o, overflow_o, frame_err_o};
        checks++;
        if (obs !== 16'h0) begin
            errors++;
            $display("FAIL midreset_outputs got=%h expected=0000", obs);
        end
        rst_ni = 1'b1;
        eb = ferr_pulses;
        cycles(TIMEOUT_CYC + 20);
        checks++;
        if (ferr_pulses - eb != 0) begin
            errors++;
            $display("FAIL midreset_no_err got=%0d expected=0", ferr_pulses - eb);
        end
        base = got_q.size();
        model_byte(8'h1E);
        send_frame(8'h1E, 1'b0, 11, -1);
        checks++;
        if (got_q.size() - base != 1 || got_q[base] !== exp_q[0]) begin
            errors++;
            $display("FAIL midreset_next n=%0d got=%h expected=%h", got_q.size() - base,
                     got_q.size() > base ? got_q[base] : 10'h0, exp_q[0]);
        end
    endtask

    task automatic test_random();
        int base;
        logic [7:0] b;
        logic [1:0] p;
        model_clear();
        ready_i = 1'b1;
        base = got_q.size();
        for (int i = 0; i < 12; i++) begin
            p = 2'($urandom_range(0, 3));
            if (p[0]) begin
                model_byte(8'hE0);
                send_frame(8'hE0, 1'b0, 11, -1);
            end
            if (p[1]) begin
                model_byte(8'hF0);
                send_frame(8'hF0, 1'b0, 11, -1);
            end
            b = 8'($urandom_range(0, 255));
            while (b == 8'hE0 || b == 8'hF0) b = 8'($urandom_range(0, 255));
            model_byte(b);
            send_frame(b, 1'b0, 11, -1);
        end
        cycles(5);
        checks++;
        if (got_q.size() - base != exp_q.size()) begin
            errors++;
            $display("FAIL random_n got=%0d expected=%0d", got_q.size() - base, exp_q.size());
        end else begin
            for (int i = 0; i < exp_q.size(); i++) begin
                checks++;
                if (got_q[base + i] !== exp_q[i]) begin
                    errors++;
                    $display("FAIL random_%0d got=%h expected=%h", i, got_q[base + i], exp_q[i]);
                end
            end
        end
    endtask

    initial begin
        test_reset();
        test_single();
        test_prefix();
        test_overflow();
        test_parity();
        test_timeout();
        test_reset_mid();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/ps2_kbd_rx.md
Name: ps2_kbd_rx

Overview:
Parametrised PS/2 keyboard receiver; successor to the digit-only PS/2 decoder. It filters the PS/2 clock, deframes 11-bit frames LSB-first with start/stop checking and a frame timeout, and tracks E0 (extended) and F0 (break) prefixes. Complete scancodes go into a first-word-fall-through FIFO with a valid/ready output handshake. The block sits between the keyboard pins and the keypad/calculator control logic.

Parameters:
FILTER_LEN, 4, consecutive equal synchronised samples required before the filtered ps2 clock changes (>=1)
TIMEOUT_CYC, 100000, clk_i cycles without a ps2 falling edge before a partial frame is aborted (>=16)
FIFO_DEPTH, 4, scancode FIFO entries; power of two, >=2

Ports:
clk_i  in  1  system clock
rst_ni  in  1  reset, asynchronous, active-low
ps2_clk_i  in  1  raw PS/2 clock line (asynchronous)
ps2_data_i  in  1  raw PS/2 data line (asynchronous)
code_o  out  8  scancode at FIFO head
extended_o  out  1  head entry was preceded by E0
release_o  out  1  head entry was preceded by F0 (key release)
valid_o  out  1  FIFO not empty; head fields valid
ready_i  in  1  consumer accepts head when valid_o && ready_i
count_o  out  $clog2(FIFO_DEPTH)+1  FIFO fill level
overflow_o  out  1  one-cycle pulse: decoded entry dropped because FIFO full
frame_err_o  out  1  one-cycle pulse: frame rejected (timeout; bad stop; bad parity if enabled)

Behaviour:
- Reset (rst_ni low, async): all outputs 0, FIFO empty, FSM IDLE, prefix flags clear, filtered clock = 1, synchronisers = 1.
- Both ps2 inputs pass a 2-FF synchroniser. Filtered clock takes the synchronised value only after FILTER_LEN consecutive equal samples. Falling edge = filtered 1->0. Data is sampled from the synchronised data line in the cycle the falling edge is detected.
- FSM states: IDLE, DATA, PARITY, STOP.
  IDLE: on edge, data 0 -> DATA (bit count 0); data 1 -> stay IDLE, no error.
  DATA: on each edge, shift data into byte LSB-first (bit0 first); after 8th bit -> PARITY.
  PARITY: capture parity bit -> STOP.
  STOP: on edge, data 1 (and parity OK when enabled) -> byte complete, IDLE; otherwise frame_err_o pulse, byte discarded, prefix flags cleared, IDLE.
- Timeout: cycle counter clears on every falling edge; in any non-IDLE state, reaching TIMEOUT_CYC -> IDLE, frame_err_o pulse, prefix flags cleared. Counter is held at 0 in IDLE.
- Decode of a completed byte, 1 cycle after the STOP edge:
  E0 -> set ext flag, no push.
  F0 -> set brk flag, no push.
  Any other byte -> push {ext, brk, byte}, then clear both flags.
- FIFO, first-word fall-through: head drives code_o/extended_o/release_o and valid_o = (count != 0). Pop on valid_o && ready_i. Output fields are don't-care when valid_o = 0 but are held stable while valid_o && !ready_i.
  Push when full without a pop in the same cycle -> entry dropped, overflow_o pulse, contents unchanged.
  Push and pop in the same cycle (including when full) -> both occur, count unchanged, no overflow. Pointers wrap modulo FIFO_DEPTH.
- Latency: valid_o rises 1 cycle after the decode push (2 cycles after the STOP falling edge is detected) when the FIFO was empty.
- rst_ni asserted mid-frame: partial frame and prefixes are discarded. No error pulse after reset release.

Optional Feature:
PS2_PARITY_CHECK_EN: when defined, a frame is accepted only if the 8 data bits plus the parity bit have an odd number of 1s; a failing frame gives a frame_err_o pulse and no decode. When undefined, the parity bit is captured and ignored, and only the stop bit and timeout produce frame_err_o.

Test Plan:
- Frame 0x16 (start 0, bits LSB-first, parity 0, stop 1), ready_i=1 -> one entry code_o=16, extended_o=0, release_o=0, valid_o high for 1 cycle.
- Sequence E0, F0, 75 -> exactly one entry code_o=75, extended_o=1, release_o=1, count_o max 1; next frame 1C gives extended_o=0, release_o=0.
- ready_i=0, FIFO_DEPTH=4, send 5 make codes 16,1E,26,25,2E -> count_o=4, overflow_o pulses once on the 5th, pops return 16,1E,26,25.
- Frame 0x16 with wrong parity: PS2_PARITY_CHECK_EN defined -> frame_err_o pulse, no entry; undefined -> entry 16.
- Stop 6 edges into a frame, idle TIMEOUT_CYC cycles -> frame_err_o pulse, FSM IDLE; a following full frame 0x45 is received correctly. A 2-cycle glitch on ps2_clk_i with FILTER_LEN=4 -> no bit sampled.
- Assert rst_ni low mid-frame after an F0 -> all outputs 0; the next frame 0x1E after release gives release_o=0.
